// File: rtl/sparse_index_merge_ctrl_pkg.sv
// Shared definitions for the sparse index merge controller.
//   IDX_W_DEF / POS_W_DEF : default index and position widths
//   state_e               : merge sequencer states
//   head_t                : one-element holding register per input stream
package sparse_index_merge_ctrl_pkg;

  localparam int unsigned IDX_W_DEF = 32;
  localparam int unsigned POS_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COMPARE,
    DECIDE,
    EMIT,
    DRAIN_A,
    DRAIN_B,
    DONE
  } state_e;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic                 last;
    logic                 full;
  } head_t;

endpackage

// File: rtl/sparse_index_merge_ctrl_cmp.sv
// Registered unsigned magnitude comparator, one cycle of latency.
//   clk     : clock
//   A, B    : operands
//   L, G, E : A<B, A>B, A==B from the previous cycle (mutually exclusive)
module sparse_index_merge_ctrl_cmp
  import sparse_index_merge_ctrl_pkg::*;
#(
  parameter int unsigned W = IDX_W_DEF
) (
  input  logic         clk,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         L,
  output logic         G,
  output logic         E
);

  logic l_d, g_d, e_d;
  logic l_q, g_q, e_q;

  always_comb begin
    l_d = (A < B);
    g_d = (A > B);
    e_d = (A == B);
  end

  always_ff @(posedge clk) begin
    l_q <= l_d;
    g_q <= g_d;
    e_q <= e_d;
  end

  assign L = l_q;
  assign G = g_q;
  assign E = e_q;

endmodule

// File: rtl/sparse_index_merge_ctrl.sv
// Intersects two ascending sparse index streams using one registered
// comparator; each common index is emitted with its position in both streams.
//   clk, rst_n                  : clock, async active-low reset
//   start                       : begin a merge (honoured only in IDLE)
//   a_valid/a_idx/a_last/a_ready: stream A (column indices)
//   b_valid/b_idx/b_last/b_ready: stream B (row indices)
//   m_valid/m_idx/m_a_pos/m_b_pos/m_ready : match output to the MAC stage
//   busy, done, match_count     : status
module sparse_index_merge_ctrl
  import sparse_index_merge_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned POS_W = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_valid,
  input  logic [IDX_W-1:0] a_idx,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [IDX_W-1:0] b_idx,
  input  logic             b_last,
  output logic             b_ready,
  output logic             m_valid,
  output logic [IDX_W-1:0] m_idx,
  output logic [POS_W-1:0] m_a_pos,
  output logic [POS_W-1:0] m_b_pos,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] match_count
);

  state_e           state_q, state_d;
  head_t            ha_q, ha_d, hb_q, hb_d;
  logic [POS_W-1:0] pa_q, pa_d, pb_q, pb_d;
  logic [POS_W-1:0] mc_q, mc_d;
  logic             cmp_l, cmp_g, cmp_e;
  logic             a_acc, b_acc;

  // Heads feed the comparator continuously; its result is only consumed in
  // DECIDE, one cycle after COMPARE presented stable heads.
  sparse_index_merge_ctrl_cmp #(
    .W (IDX_W)
  ) u_cmp (
    .clk (clk),
    .A   (ha_q.idx),
    .B   (hb_q.idx),
    .L   (cmp_l),
    .G   (cmp_g),
    .E   (cmp_e)
  );

  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ha_q    <= '0;
      hb_q    <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      ha_q    <= ha_d;
      hb_q    <= hb_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      mc_q    <= mc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ha_d    = ha_q;
    hb_d    = hb_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    mc_d    = mc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ha_d    = '0;
          hb_d    = '0;
          pa_d    = '0;
          pb_d    = '0;
          mc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (a_acc) begin
          ha_d.idx  = a_idx;
          ha_d.last = a_last;
          ha_d.full = 1'b1;
        end
        if (b_acc) begin
          hb_d.idx  = b_idx;
          hb_d.last = b_last;
          hb_d.full = 1'b1;
        end
        if (ha_d.full && hb_d.full) state_d = COMPARE;
      end
      COMPARE: state_d = DECIDE;
      DECIDE: begin
        unique case ({cmp_l, cmp_g, cmp_e})
          3'b100: begin
            ha_d.full = 1'b0;
            pa_d      = pa_q + POS_W'(1);
            state_d   = ha_q.last ? DRAIN_B : FETCH;
          end
          3'b010: begin
            hb_d.full = 1'b0;
            pb_d      = pb_q + POS_W'(1);
            state_d   = hb_q.last ? DRAIN_A : FETCH;
          end
          3'b001:  state_d = EMIT;
          default: state_d = COMPARE;
        endcase
      end
      EMIT: begin
        if (m_ready) begin
          mc_d      = mc_q + POS_W'(1);
          pa_d      = pa_q + POS_W'(1);
          pb_d      = pb_q + POS_W'(1);
          ha_d.full = 1'b0;
          hb_d.full = 1'b0;
          unique case ({ha_q.last, hb_q.last})
            2'b11:   state_d = DONE;
            2'b10:   state_d = DRAIN_B;
            2'b01:   state_d = DRAIN_A;
            default: state_d = FETCH;
          endcase
        end
      end
      // A held head that already carries last ends the drain without a
      // handshake; otherwise the head is discarded and upstream is pulled
      // until its last element goes by.
      DRAIN_A: begin
        ha_d.full = 1'b0;
        if ((ha_q.full && ha_q.last) || (a_acc && a_last)) state_d = DONE;
      end
      DRAIN_B: begin
        hb_d.full = 1'b0;
        if ((hb_q.full && hb_q.last) || (b_acc && b_last)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    m_valid     = 1'b0;
    m_idx       = '0;
    m_a_pos     = '0;
    m_b_pos     = '0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    match_count = mc_q;
    unique case (state_q)
      FETCH: begin
        a_ready = !ha_q.full;
        b_ready = !hb_q.full;
      end
      EMIT: begin
        m_valid = 1'b1;
        m_idx   = ha_q.idx;
        m_a_pos = pa_q;
        m_b_pos = pb_q;
      end
      DRAIN_A: a_ready = !(ha_q.full && ha_q.last);
      DRAIN_B: b_ready = !(hb_q.full && hb_q.last);
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sparse_index_merge_ctrl.sv
module tb_sparse_index_merge_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        a_valid = 1'b0, a_last = 1'b0;
  logic        b_valid = 1'b0, b_last = 1'b0;
  logic [31:0] a_idx = '0, b_idx = '0;
  logic        m_ready = 1'b1;

  logic        n_a_ready, n_b_ready, n_m_valid, n_busy, n_done;
  logic [31:0] n_m_idx;
  logic [15:0] n_m_a_pos, n_m_b_pos, n_mc;
  logic        w_a_ready, w_b_ready, w_m_valid, w_busy, w_done;
  logic [31:0] w_m_idx;
  logic [3:0]  w_m_a_pos, w_m_b_pos, w_mc;

  logic        t_a_ready, t_b_ready, t_m_valid, t_busy, t_done;
  logic [31:0] t_m_idx;
  logic [15:0] t_m_a_pos, t_m_b_pos, t_mc;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned a_q[$], b_q[$];
  int unsigned e_idx[$], e_ap[$], e_bp[$];

  always #5 clk = ~clk;

  sparse_index_merge_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel),
    .a_valid(a_valid), .a_idx(a_idx), .a_last(a_last), .a_ready(n_a_ready),
    .b_valid(b_valid), .b_idx(b_idx), .b_last(b_last), .b_ready(n_b_ready),
    .m_valid(n_m_valid), .m_idx(n_m_idx), .m_a_pos(n_m_a_pos), .m_b_pos(n_m_b_pos),
    .m_ready(m_ready), .busy(n_busy), .done(n_done), .match_count(n_mc)
  );

  sparse_index_merge_ctrl #(.IDX_W(32), .POS_W(4)) u_dut_p4 (
    .clk(clk), .rst_n(rst_n), .start(start & sel),
    .a_valid(a_valid), .a_idx(a_idx), .a_last(a_last), .a_ready(w_a_ready),
    .b_valid(b_valid), .b_idx(b_idx), .b_last(b_last), .b_ready(w_b_ready),
    .m_valid(w_m_valid), .m_idx(w_m_idx), .m_a_pos(w_m_a_pos), .m_b_pos(w_m_b_pos),
    .m_ready(m_ready), .busy(w_busy), .done(w_done), .match_count(w_mc)
  );

  assign t_a_ready = sel ? w_a_ready : n_a_ready;
  assign t_b_ready = sel ? w_b_ready : n_b_ready;
  assign t_m_valid = sel ? w_m_valid : n_m_valid;
  assign t_busy    = sel ? w_busy    : n_busy;
  assign t_done    = sel ? w_done    : n_done;
  assign t_m_idx   = sel ? w_m_idx   : n_m_idx;
  assign t_m_a_pos = sel ? {12'b0, w_m_a_pos} : n_m_a_pos;
  assign t_m_b_pos = sel ? {12'b0, w_m_b_pos} : n_m_b_pos;
  assign t_mc      = sel ? {12'b0, w_mc}      : n_mc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_match(input int unsigned idx, input int unsigned ap, input int unsigned bp);
    e_idx.push_back(idx);
    e_ap.push_back(ap);
    e_bp.push_back(bp);
  endtask

  task automatic clear_vectors();
    a_q.delete(); b_q.delete();
    e_idx.delete(); e_ap.delete(); e_bp.delete();
  endtask

  // Runs one merge from the current vectors. hold_n: cycles m_ready is held
  // low on each match; poke_at: cycle of a spurious start (-1 none);
  // abort: pulse reset as soon as m_valid appears.
  task automatic run_merge(input string name, input int hold_n, input bit gaps,
                           input int poke_at, input bit abort, input int exp_mc,
                           input bit chk_done_lat);
    int a_ptr = 0, b_ptr = 0, nmatch = 0, cyc = 0, held = 0;
    int xfer_cyc = -100, done_cyc = -1, hold_left;
    bit a_hold = 0, b_hold = 0, cap_ok = 0;
    logic [31:0] cap_idx;
    logic [15:0] cap_ap, cap_bp;
    hold_left = hold_n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 2000 && done_cyc < 0) begin
      if (t_done) done_cyc = cyc;
      start = (cyc == poke_at);
      m_ready = 1'b1;
      if (t_m_valid && abort) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq({name, "_rst_mvalid"}, t_m_valid, 0);
        check_eq({name, "_rst_busy"}, t_busy, 0);
        check_eq({name, "_rst_midx"}, t_m_idx, 0);
        check_eq({name, "_rst_mc"}, t_mc, 0);
        a_valid = 1'b0; b_valid = 1'b0; start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (t_m_valid && hold_left > 0) begin
        m_ready = 1'b0;
        held++;
        if (cap_ok) begin
          check_eq({name, "_hold_idx"}, t_m_idx, cap_idx);
          check_eq({name, "_hold_apos"}, t_m_a_pos, cap_ap);
          check_eq({name, "_hold_bpos"}, t_m_b_pos, cap_bp);
        end
        cap_idx = t_m_idx; cap_ap = t_m_a_pos; cap_bp = t_m_b_pos; cap_ok = 1;
        hold_left--;
      end
      if (!a_hold) a_valid = (a_ptr < a_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
      if (!b_hold) b_valid = (b_ptr < b_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
      a_idx  = (a_ptr < a_q.size()) ? a_q[a_ptr] : 32'd0;
      a_last = (a_ptr == a_q.size() - 1);
      b_idx  = (b_ptr < b_q.size()) ? b_q[b_ptr] : 32'd0;
      b_last = (b_ptr == b_q.size() - 1);
      #1;
      if (a_valid && t_a_ready) begin a_ptr++; a_hold = 0; end else a_hold = a_valid;
      if (b_valid && t_b_ready) begin b_ptr++; b_hold = 0; end else b_hold = b_valid;
      if (t_m_valid && m_ready) begin
        if (nmatch < e_idx.size()) begin
          check_eq({name, "_m_idx"}, t_m_idx, e_idx[nmatch]);
          check_eq({name, "_m_apos"}, t_m_a_pos, e_ap[nmatch]);
          check_eq({name, "_m_bpos"}, t_m_b_pos, e_bp[nmatch]);
        end else begin
          check_eq({name, "_extra_match"}, 1, 0);
        end
        nmatch++; xfer_cyc = cyc; cap_ok = 0; hold_left = hold_n;
      end
      @(negedge clk);
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    check_eq({name, "_done_seen"}, done_cyc >= 0, 1);
    check_eq({name, "_nmatch"}, nmatch, e_idx.size());
    check_eq({name, "_a_consumed"}, a_ptr, a_q.size());
    check_eq({name, "_b_consumed"}, b_ptr, b_q.size());
    check_eq({name, "_match_count"}, t_mc, exp_mc);
    if (hold_n > 0) check_eq({name, "_held_cycles"}, held, hold_n);
    if (chk_done_lat) check_eq({name, "_done_lat"}, done_cyc - xfer_cyc, 1);
    // Cycle after DONE: back in IDLE, pulse gone, count held.
    check_eq({name, "_done_pulse"}, t_done, 0);
    check_eq({name, "_idle"}, t_busy, 0);
    @(negedge clk);
    check_eq({name, "_mc_held"}, t_mc, exp_mc);
  endtask

  initial begin
    #2;
    check_eq("rst_busy", t_busy, 0);
    check_eq("rst_done", t_done, 0);
    check_eq("rst_mvalid", t_m_valid, 0);
    check_eq("rst_a_ready", t_a_ready, 0);
    check_eq("rst_b_ready", t_b_ready, 0);
    check_eq("rst_mc", t_mc, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic intersection, spurious start while busy, B tail drained.
    clear_vectors();
    a_q = '{1, 4, 7, 9}; b_q = '{2, 4, 9, 12};
    add_match(4, 1, 1); add_match(9, 3, 2);
    run_merge("t1", 0, 0, 4, 0, 2, 0);

    // Disjoint streams: A runs out first, B drained.
    clear_vectors();
    a_q = '{3, 5}; b_q = '{10, 20};
    run_merge("t2", 0, 0, -1, 0, 0, 0);

    // Single-element streams with downstream back-pressure.
    clear_vectors();
    a_q = '{6}; b_q = '{6};
    add_match(6, 0, 0);
    run_merge("t3", 5, 0, -1, 0, 1, 1);

    // Identical streams with random valid gaps.
    clear_vectors();
    for (int i = 0; i < 16; i++) begin
      a_q.push_back(i); b_q.push_back(i); add_match(i, i, i);
    end
    run_merge("t4", 0, 1, -1, 0, 16, 0);

    // Reset while in EMIT, then a clean rerun of the same vectors.
    clear_vectors();
    a_q = '{2, 8}; b_q = '{2};
    run_merge("t5a", 0, 0, -1, 1, 0, 0);
    @(negedge clk);
    add_match(2, 0, 0);
    run_merge("t5b", 0, 0, -1, 0, 1, 0);

    // Narrow position counters wrap.
    clear_vectors();
    sel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_q.push_back(i); b_q.push_back(i); add_match(i, i % 16, i % 16);
    end
    run_merge("t6", 0, 0, -1, 0, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_index_merge_ctrl.md
Name: sparse_index_merge_ctrl

Overview:
- Sequences a single 32-bit registered comparator (one-cycle latency, exclusive L/G/E flags) to intersect two ascending-sorted sparse index streams.
- Stream A carries the sparse row's column indices; stream B carries the dense/sparse operand's row indices.
- On each index match, emits the element positions of both streams to the MAC stage.
- Sits between the CSR/CSC fetch units and the multiply-accumulate datapath.

Parameters:
IDX_W, 32, index width; must equal the comparator operand width.
POS_W, 16, width of the per-stream element-position counters and of match_count.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a merge. Ignored unless in IDLE.
a_valid  in  1  stream A element valid.
a_idx  in  IDX_W  stream A index.
a_last  in  1  final element of stream A.
a_ready  out  1  stream A accept.
b_valid  in  1  stream B element valid.
b_idx  in  IDX_W  stream B index.
b_last  in  1  final element of stream B.
b_ready  out  1  stream B accept.
m_valid  out  1  match output valid.
m_idx  out  IDX_W  matched index value.
m_a_pos  out  POS_W  zero-based position of the match in stream A.
m_b_pos  out  POS_W  zero-based position of the match in stream B.
m_ready  in  1  downstream accept.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the merge completes.
match_count  out  POS_W  matches emitted in the current or last merge; held until the next start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; head registers, position counters and match_count cleared. Reset asserted mid-merge aborts immediately. No element is consumed on the reset edge.
- Handshake: a transfer occurs on a cycle with valid&ready. m_valid, m_idx, m_a_pos and m_b_pos stay stable until m_ready. Ready outputs are never dependent on the same-cycle valid.
- Internal state: head registers ha/hb (idx, last, full) and position counters pa/pb.
- IDLE: on start, clear pa, pb, heads and match_count; go to FETCH.
- FETCH:
  - a_ready = !ha.full; b_ready = !hb.full.
  - An accepted element loads its head and sets full.
  - When both heads are full, go to COMPARE.
- COMPARE: drive ha.idx/hb.idx to the comparator for one cycle (registered result), then go to DECIDE.
- DECIDE:
  - L: drop head A and increment pa. If ha.last, go to DRAIN_B; else go to FETCH.
  - G: drop head B and increment pb. If hb.last, go to DRAIN_A; else go to FETCH.
  - E: go to EMIT.
- EMIT:
  - m_valid=1, m_idx=ha.idx, m_a_pos=pa, m_b_pos=pb.
  - On m_ready: increment match_count, drop both heads, increment pa and pb.
  - If both lasts are set, go to DONE. If only ha.last, go to DRAIN_B. If only hb.last, go to DRAIN_A. Otherwise go to FETCH.
- DRAIN_A/DRAIN_B:
  - Discard the surviving stream up to and including its last element, so upstream is always left aligned.
  - If the held head of that stream already has last set, drop it and go to DONE with no handshake.
  - Otherwise drop any held head, assert ready on that stream, and go to DONE on the handshake where last=1.
- DONE: done=1 for one cycle, busy=1; then go to IDLE.
- Latency: minimum 3 cycles per decision (FETCH, COMPARE, DECIDE), plus EMIT ≥1 cycle on a match.
- Width rules:
  - Indices are unsigned.
  - pa and pb wrap modulo 2^POS_W; no saturation and no error flag.
  - match_count wraps the same way.
- Simultaneous events:
  - Both streams may be accepted in the same FETCH cycle.
  - start while busy is ignored.
  - Duplicate indices within a stream are not supported; behaviour is defined only for strictly ascending input.
  - A single-element stream is legal.

Decomposition:
- Shared package holds: IDX_W/POS_W defaults, the state enumeration (IDLE, FETCH, COMPARE, DECIDE, EMIT, DRAIN_A, DRAIN_B, DONE), and a head-register struct (idx, last, full).
- One sub-module is natural: the existing comparator (clk, A, B, L, G, E), instantiated once. Its outputs are sampled only in DECIDE.

Test Plan:
- A={1,4,7,9}, B={2,4,9,12}, m_ready=1 → matches (4,a1,b1) and (9,a3,b2); B element 12 drained; match_count=2; done pulse once.
- A={3,5}, B={10,20} → no m_valid; A exhausts first; B fully drained; match_count=0; done.
- A={6}, B={6}, m_ready held low 5 cycles → m_valid and data stable for all 5 cycles; single transfer; match_count=1; done next.
- Random valid gaps on both streams, A=B={0..15} → 16 matches with m_a_pos=m_b_pos=0..15 in order, no element lost or duplicated.
- rst_n pulsed low in EMIT during A={2,8}, B={2} → outputs 0 asynchronously; IDLE; a fresh start gives a correct result.
- POS_W=4, A=B=0..19 → positions wrap 15→0; match_count=4 (20 mod 16); no hang.
